// File: rtl/nanov_regfile_serial.sv
// nanoV bit-serial register file: B bits/clock, 16 or 32 entries, realign FSM.
// Optional same-cycle forwarding of data_rd: define NANOV_REGFILE_BYPASS_EN.
module nanov_regfile_serial #(
  parameter int XLEN     = 32,
  parameter int B        = 1,
  parameter int NUM_REGS = 16,
  localparam int S  = XLEN / B,
  localparam int PW = (S > 1) ? $clog2(S) : 1,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          shift_en,
  input  logic          wr_en,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [B-1:0]  data_rd,
  output logic [B-1:0]  data_rs1,
  output logic [B-1:0]  data_rs2,
  input  logic          align_req,
  output logic          busy,
  output logic          aligned,
  output logic [PW-1:0] pos,
  output logic          word_start,
  output logic          word_end
);

  typedef enum logic {
    RUN,
    ALIGN
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]   pos_q;
  logic            aligned_q;
  logic            aligned_d;
  logic            shift;
  logic            wr_act;
  logic            last_slice;
  logic [B-1:0]    st_rs1;
  logic [B-1:0]    st_rs2;
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];

  assign last_slice = (pos_q == PW'(S - 1));

  // An align request in RUN takes the cycle: no shift, no write.
  always_comb begin
    state_d   = state_q;
    shift     = 1'b0;
    aligned_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (align_req) begin
          if (pos_q == '0) begin
            aligned_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end else begin
          shift = shift_en;
        end
      end
      ALIGN: begin
        shift = 1'b1;
        if (last_slice) begin
          state_d   = RUN;
          aligned_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign wr_act = (state_q == RUN) && shift && wr_en && (rd != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      pos_q     <= '0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aligned_q <= aligned_d;
      if (shift) begin
        pos_q <= last_slice ? '0 : pos_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (shift) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {(wr_act && rd == RW'(i)) ? data_rd
                                               : regs_q[i][B-1:0],
                      regs_q[i][XLEN-1:B]};
      end
    end
  end

  always_comb begin
    st_rs1 = '0;
    st_rs2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == RW'(i)) st_rs1 = regs_q[i][B-1:0];
      if (rs2 == RW'(i)) st_rs2 = regs_q[i][B-1:0];
    end
  end

`ifdef NANOV_REGFILE_BYPASS_EN
  assign data_rs1 = (wr_act && rs1 == rd) ? data_rd : st_rs1;
  assign data_rs2 = (wr_act && rs2 == rd) ? data_rd : st_rs2;
`else
  assign data_rs1 = st_rs1;
  assign data_rs2 = st_rs2;
`endif

  assign busy       = (state_q == ALIGN);
  assign aligned    = aligned_q;
  assign pos        = pos_q;
  assign word_start = (pos_q == '0);
  assign word_end   = last_slice;

endmodule

// File: tb/tb_nanov_regfile_serial.sv
// Self-checking bench for nanov_regfile_serial (B=4, 32 entries).
// Word-level reference model; slices picked by position arithmetic.
module tb_nanov_regfile_serial;

  localparam int XLEN = 32;
  localparam int B    = 4;
  localparam int NR   = 32;
  localparam int S    = XLEN / B;
  localparam int PW   = 3;
  localparam int RW   = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          shift_en = 1'b0;
  logic          wr_en = 1'b0;
  logic          align_req = 1'b0;
  logic [RW-1:0] rs1 = '0;
  logic [RW-1:0] rs2 = '0;
  logic [RW-1:0] rd = '0;
  logic [B-1:0]  data_rd = '0;
  logic [B-1:0]  data_rs1;
  logic [B-1:0]  data_rs2;
  logic          busy;
  logic          aligned;
  logic [PW-1:0] pos;
  logic          word_start;
  logic          word_end;

  nanov_regfile_serial #(
    .XLEN(XLEN),
    .B(B),
    .NUM_REGS(NR)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .shift_en(shift_en),
    .wr_en(wr_en),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .data_rd(data_rd),
    .data_rs1(data_rs1),
    .data_rs2(data_rs2),
    .align_req(align_req),
    .busy(busy),
    .aligned(aligned),
    .pos(pos),
    .word_start(word_start),
    .word_end(word_end)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [XLEN-1:0] mw [NR];
  int mpos;
  bit m_align;
  bit m_al;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) mw[i] = '0;
    mpos = 0;
    m_align = 1'b0;
    m_al = 1'b0;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  function automatic logic [B-1:0] exp_rd(logic [RW-1:0] rs);
    logic [B-1:0] v;
    v = (rs == 0) ? '0 : mw[rs][mpos*B +: B];
`ifdef NANOV_REGFILE_BYPASS_EN
    if (!m_align && shift_en && !align_req && wr_en &&
        rd != 0 && rs == rd) v = data_rd;
`endif
    return v;
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".rs1"}, 32'(data_rs1), 32'(exp_rd(rs1)));
    chk({tag, ".rs2"}, 32'(data_rs2), 32'(exp_rd(rs2)));
    chk({tag, ".pos"}, 32'(pos), mpos);
    chk({tag, ".busy"}, 32'(busy), 32'(m_align));
    chk({tag, ".aligned"}, 32'(aligned), 32'(m_al));
    chk({tag, ".ws"}, 32'(word_start), 32'(mpos == 0));
    chk({tag, ".we"}, 32'(word_end), 32'(mpos == S - 1));
  endtask

  // Model step at the active edge, from the inputs held across it.
  task automatic upd();
    if (!rstn) begin
      m_reset();
    end else if (m_align) begin
      mpos = (mpos + 1) % S;
      m_al = (mpos == 0);
      if (mpos == 0) m_align = 1'b0;
    end else if (align_req) begin
      m_al = (mpos == 0);
      m_align = (mpos != 0);
    end else begin
      m_al = 1'b0;
      if (shift_en) begin
        if (wr_en && rd != 0) mw[rd][mpos*B +: B] = data_rd;
        mpos = (mpos + 1) % S;
      end
    end
  endtask

  task automatic cyc(string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    logic [31:0] w;
    int nbusy;
    int nal;

    m_reset();
    @(negedge clk);
    check_all("reset");
    for (int i = 0; i < NR; i++) begin
      rs1 = RW'(i);
      rs2 = RW'(NR - 1 - i);
      #1;
      chk("rst_rs1", 32'(data_rs1), 0);
      chk("rst_rs2", 32'(data_rs2), 0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    w = 32'hDEADBEEF;
    shift_en = 1'b1;
    wr_en = 1'b1;
    rd = 5'd5;
    rs1 = 5'd5;
    rs2 = 5'd0;
    for (int i = 0; i < S; i++) begin
      data_rd = w[i*B +: B];
      cyc("wr5");
    end

    rd = 5'd0;
    for (int i = 0; i < S; i++) begin
      data_rd = B'($urandom);
      chk("rd5_slice", 32'(data_rs1), 32'(w[i*B +: B]));
      chk("x0_zero", 32'(data_rs2), 0);
      cyc("rd5");
    end

    wr_en = 1'b0;
    rd = 5'd5;
    for (int i = 0; i < 3; i++) cyc("pre_stall");
    shift_en = 1'b0;
    wr_en = 1'b1;
    data_rd = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pos", 32'(pos), 3);
      chk("stall_rs1", 32'(data_rs1), 32'(w[3*B +: B]));
      cyc("stall");
    end
    shift_en = 1'b1;
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) cyc("to5");

    shift_en = 1'b0;
    align_req = 1'b1;
    cyc("areq5");
    nbusy = 0;
    nal = 0;
    for (int i = 0; i < 5; i++) begin
      align_req = (i == 1);
      if (busy) nbusy++;
      if (aligned) nal++;
      cyc("align5");
    end
    align_req = 1'b0;
    chk("align_busy_cnt", nbusy, 3);
    chk("align_pulse_cnt", nal, 1);

    shift_en = 1'b1;
    rs1 = 5'd5;
    for (int i = 0; i < S; i++) begin
      chk("post_align_rd5", 32'(data_rs1), 32'(w[i*B +: B]));
      cyc("post_align");
    end

    shift_en = 1'b0;
    align_req = 1'b1;
    cyc("areq0");
    align_req = 1'b0;
    chk("a0_pulse", 32'(aligned), 1);
    chk("a0_pos", 32'(pos), 0);
    cyc("a0p");
    cyc("a0q");

    w = 32'h12345678;
    shift_en = 1'b1;
    wr_en = 1'b1;
    rd = 5'd31;
    rs2 = 5'd31;
    for (int i = 0; i < S; i++) begin
      data_rd = w[i*B +: B];
`ifdef NANOV_REGFILE_BYPASS_EN
      chk("byp_rs2", 32'(data_rs2), 32'(data_rd));
`else
      chk("nobyp_rs2", 32'(data_rs2), 0);
`endif
      cyc("wr31");
    end
    wr_en = 1'b0;
    for (int i = 0; i < S; i++) begin
      chk("rd31_slice", 32'(data_rs2), 32'(w[i*B +: B]));
      cyc("rd31");
    end

    repeat (400) begin
      shift_en = ($urandom_range(0, 9) < 7);
      wr_en = $urandom_range(0, 1) == 1;
      rd = RW'($urandom);
      rs1 = RW'($urandom);
      rs2 = $urandom_range(0, 3) == 0 ? rd : RW'($urandom);
      data_rd = B'($urandom);
      align_req = ($urandom_range(0, 19) == 0);
      if (align_req) begin
        shift_en = 1'b0;
        wr_en = 1'b0;
      end
      cyc("rand");
    end

    shift_en = 1'b0;
    wr_en = 1'b0;
    align_req = 1'b0;
    for (int i = 0; i < 2 * S && m_align; i++) cyc("drain");
    if (mpos != 0) begin
      align_req = 1'b1;
      cyc("drain_req");
      align_req = 1'b0;
      for (int i = 0; i < 2 * S && m_align; i++) cyc("drain2");
    end
    chk("drain_done", 32'(busy), 0);

    shift_en = 1'b1;
    for (int i = 0; i < 4; i++) cyc("to4");
    shift_en = 1'b0;
    align_req = 1'b1;
    cyc("areq4");
    align_req = 1'b0;
    cyc("al5");
    cyc("al6");
    chk("mid_pos6", 32'(pos), 6);
    chk("mid_busy", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    m_reset();
    #1;
    chk("rst_mid_pos", 32'(pos), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_al", 32'(aligned), 0);
    for (int i = 0; i < NR; i++) begin
      rs1 = RW'(i);
      #0.1;
      chk("rst_mid_rs1", 32'(data_rs1), 0);
    end
    cyc("rst_hold");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cyc("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
